// File: rtl/vga_ctrl_pkg.sv
// Shared sprite-path widths, load-kind encodings and the update arbiter
// state encoding.
package vga_ctrl_pkg;

  localparam int SPR_SEL_W = 5;
  localparam int X_W       = 10;
  localparam int Y_W       = 9;

  localparam logic [1:0] KIND_POS = 2'b01;
  localparam logic [1:0] KIND_ATT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_ISSUE,
    ST_SETTLE
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping at N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 any_req
);

  localparam int IW = $clog2(N);

  logic found;
  int   j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (!found && req[j]) begin
        found     = 1'b1;
        grant[j]  = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/sprite_update_arbiter.sv
// Shares the sprite engine load port among requesters, committing
// updates only inside vertical blanking with a per-blank budget.
module sprite_update_arbiter
  import vga_ctrl_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int SETTLE_CYC    = 2,
  parameter int MAX_PER_BLANK = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       vblank,
  input  logic [N_REQ-1:0]           req,
  input  logic [2*N_REQ-1:0]         req_kind,
  input  logic [SPR_SEL_W*N_REQ-1:0] req_sel,
  input  logic [X_W*N_REQ-1:0]       req_x,
  input  logic [Y_W*N_REQ-1:0]       req_y,
  input  logic [N_REQ-1:0]           req_vis,
  output logic [N_REQ-1:0]           ack,
  output logic [SPR_SEL_W-1:0]       sprite_sel,
  output logic [X_W-1:0]             x,
  output logic [Y_W-1:0]             y,
  output logic                       visable,
  output logic                       load_pos,
  output logic                       load_att,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_PER_BLANK + 1);
  localparam int CW = $clog2(SETTLE_CYC + 1);

  arb_state_e     state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gidx_q;
  logic [BW-1:0]  budget;
  logic [CW-1:0]  settle_cnt;

  logic [N_REQ-1:0] grant;
  logic [IW-1:0]    gidx;
  logic             any_req;
  logic             go;
  logic [1:0]       kind;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (gidx),
    .any_req   (any_req)
  );

  assign go   = vblank && any_req && (budget < BW'(MAX_PER_BLANK));
  assign kind = req_kind[gidx*2 +: 2];
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      gidx_q     <= '0;
      budget     <= '0;
      settle_cnt <= '0;
      ack        <= '0;
      sprite_sel <= '0;
      x          <= '0;
      y          <= '0;
      visable    <= 1'b0;
      load_pos   <= 1'b0;
      load_att   <= 1'b0;
    end else begin
      ack      <= '0;
      load_pos <= 1'b0;
      load_att <= 1'b0;
      if (!vblank) budget <= '0;
      unique case (state)
        ST_IDLE: begin
          if (go) state <= ST_ARB;
        end
        ST_ARB: begin
          if (vblank && any_req) begin
            // strobes are registered here so they appear in the ISSUE cycle
            state      <= ST_ISSUE;
            gidx_q     <= gidx;
            ack        <= grant;
            load_pos   <= |(kind & KIND_POS);
            load_att   <= |(kind & KIND_ATT);
            sprite_sel <= req_sel[gidx*SPR_SEL_W +: SPR_SEL_W];
            x          <= req_x[gidx*X_W +: X_W];
            y          <= req_y[gidx*Y_W +: Y_W];
            visable    <= req_vis[gidx];
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (vblank && budget < BW'(MAX_PER_BLANK))
            budget <= budget + 1'b1;
          ptr <= (gidx_q == IW'(N_REQ - 1)) ? '0 : gidx_q + 1'b1;
          settle_cnt <= CW'(SETTLE_CYC - 1);
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt == '0)
            state <= go ? ST_ARB : ST_IDLE;
          else
            settle_cnt <= settle_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
